decimal_para_binario: RTL and testbench



---
 rtl/decimal_para_binario_pkg.sv | 18 +
 rtl/decimal_para_binario_mul10_add.sv | 20 ++
 rtl/decimal_para_binario.sv | 149 ++++++++++++++
 tb/tb_decimal_para_binario.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/decimal_para_binario_pkg.sv
// Shared types and constants for the decimal-entry converter.
// Optional digit echo is enabled with the DIGIT_ECHO_EN macro.
package decimal_para_binario_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam int         DECIMAL_BASE = 10;

   function automatic logic is_bcd(input logic [3:0] d);
      return d <= BCD_MAX;
   endfunction

endpackage

// File: rtl/decimal_para_binario_mul10_add.sv
// Combinational acc*10 + digit, truncated to WIDTH bits.
// Shift-and-add form avoids a generic multiplier.
module mul10_add #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_acc,
   input  logic [3:0]       i_digit,
   output logic [WIDTH-1:0] o_result
);

   logic [WIDTH-1:0] w_x8;
   logic [WIDTH-1:0] w_x2;
   logic [WIDTH-1:0] w_digit;

   assign w_x8     = i_acc << 3;
   assign w_x2     = i_acc << 1;
   assign w_digit  = {{(WIDTH-4){1'b0}}, i_digit};
   assign o_result = w_x8 + w_x2 + w_digit;

endmodule

// File: rtl/decimal_para_binario.sv
// Sequential BCD-entry to binary converter with valid/ready output.
// Define DIGIT_ECHO_EN to build the echo_tens/echo_units shift registers.
module decimal_para_binario
   import decimal_para_binario_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MAX_DIGITS = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [3:0]                        digit_in,
   input  logic                              digit_valid,
   input  logic                              commit,
   input  logic                              clear,
   output logic [WIDTH-1:0]                  out_value,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
   output logic                              err,
   output logic [3:0]                        echo_tens,
   output logic [3:0]                        echo_units
);

   localparam int CW = $clog2(MAX_DIGITS+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_acc_mul;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] r_out_value;
   logic [WIDTH-1:0] w_out_value_nxt;
   logic             r_out_valid;
   logic             w_out_valid_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_accept;
   logic             w_flush;
   logic             w_digit_ok;

   mul10_add #(
      .WIDTH    (WIDTH)
   ) u_mul10_add (
      .i_acc    (r_acc),
      .i_digit  (digit_in),
      .o_result (w_acc_mul)
   );

   assign w_digit_ok = is_bcd(digit_in) && (r_cnt < CNT_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_value <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_value <= w_out_value_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_err       <= w_err_nxt;
      end
   end

   // Strobe priority: clear, then commit, then digit_valid.
   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_out_value_nxt = r_out_value;
      w_out_valid_nxt = r_out_valid;
      w_err_nxt       = r_err;
      w_accept        = 1'b0;
      w_flush         = 1'b0;
      if (clear) begin
         w_state_nxt     = IDLE;
         w_acc_nxt       = '0;
         w_cnt_nxt       = '0;
         w_out_valid_nxt = 1'b0;
         w_err_nxt       = 1'b0;
         w_flush         = 1'b1;
      end else begin
         unique case (r_state)
            IDLE, ENTRY: begin
               if (commit && r_state == ENTRY) begin
                  w_out_value_nxt = r_acc;
                  w_out_valid_nxt = 1'b1;
                  w_state_nxt     = HOLD;
               end else if (digit_valid) begin
                  if (w_digit_ok) begin
                     w_acc_nxt   = w_acc_mul;
                     w_cnt_nxt   = r_cnt + CW'(1);
                     w_state_nxt = ENTRY;
                     w_accept    = 1'b1;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (r_out_valid && out_ready) begin
                  w_out_valid_nxt = 1'b0;
                  w_acc_nxt       = '0;
                  w_cnt_nxt       = '0;
                  w_state_nxt     = IDLE;
                  w_flush         = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

`ifdef DIGIT_ECHO_EN
   logic [3:0] r_echo_tens;
   logic [3:0] r_echo_units;

   always_ff @(posedge clk) begin
      if (!rst_n || w_flush) begin
         r_echo_tens  <= '0;
         r_echo_units <= '0;
      end else if (w_accept) begin
         r_echo_tens  <= r_echo_units;
         r_echo_units <= digit_in;
      end
   end

   assign echo_tens  = r_echo_tens;
   assign echo_units = r_echo_units;
`else
   assign echo_tens  = 4'd0;
   assign echo_units = 4'd0;
`endif

   assign out_value   = r_out_value;
   assign out_valid   = r_out_valid;
   assign digit_count = r_cnt;
   assign err         = r_err;

endmodule

// File: tb/tb_decimal_para_binario.sv
// Randomized bench for decimal_para_binario against an arithmetic model.
// Echo expectations follow the DIGIT_ECHO_EN macro.
module tb_decimal_para_binario;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  digit_in;
   logic        digit_valid;
   logic        commit;
   logic        clear;
   logic [31:0] out_value;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  digit_count;
   logic        err;
   logic [3:0]  echo_tens;
   logic [3:0]  echo_units;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state: plain integers and a digit history.
   int unsigned m_acc;
   int          m_cnt;
   bit          m_hold;
   bit          m_valid;
   bit          m_err;
   int unsigned m_out;
   int          m_tens;
   int          m_units;

   decimal_para_binario dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .commit      (commit),
      .clear       (clear),
      .out_value   (out_value),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .digit_count (digit_count),
      .err         (err),
      .echo_tens   (echo_tens),
      .echo_units  (echo_units)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit rn, input bit clr, input bit cmt,
                             input bit dv, input int d, input bit rdy);
      if (!rn || clr) begin
         m_acc = 0; m_cnt = 0; m_hold = 0; m_valid = 0;
         m_err = 0; m_tens = 0; m_units = 0;
         if (!rn) m_out = 0;
      end else if (m_hold) begin
         if (rdy) begin
            m_hold = 0; m_valid = 0; m_acc = 0; m_cnt = 0;
            m_tens = 0; m_units = 0;
         end
      end else if (cmt && m_cnt > 0) begin
         m_out = m_acc; m_valid = 1; m_hold = 1;
      end else if (dv) begin
         if (d <= 9 && m_cnt < 2) begin
            m_acc = m_acc * 10 + d;
            m_cnt++;
            m_tens  = m_units;
            m_units = d;
         end else begin
            m_err = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("out_value", out_value, m_out);
      chk("digit_count", digit_count, m_cnt);
      chk("err", err, m_err);
`ifdef DIGIT_ECHO_EN
      chk("echo_tens", echo_tens, m_tens);
      chk("echo_units", echo_units, m_units);
`else
      chk("echo_tens", echo_tens, 0);
      chk("echo_units", echo_units, 0);
`endif
   endtask

   task automatic step(input bit rn, input bit clr, input bit cmt,
                       input bit dv, input int d, input bit rdy);
      rst_n       = rn;
      clear       = clr;
      commit      = cmt;
      digit_valid = dv;
      digit_in    = 4'(d);
      out_ready   = rdy;
      @(posedge clk);
      model_step(rn, clr, cmt, dv, d, rdy);
      #1;
      check_all();
   endtask

   task automatic dig(input int d);
      step(1, 0, 0, 1, d, 0);
   endtask

   task automatic idle(input bit rdy);
      step(1, 0, 0, 0, 0, rdy);
   endtask

   initial begin
      m_acc = 0; m_cnt = 0; m_hold = 0; m_valid = 0;
      m_err = 0; m_out = 0; m_tens = 0; m_units = 0;

      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("rst_value", out_value, 0);

      // 4, 2, commit with ready high: one valid cycle of 42
      dig(4); dig(2);
      step(1, 0, 1, 0, 0, 1);
      chk("t1_value", out_value, 42);
      chk("t1_valid", out_valid, 1);
      idle(1);
      chk("t1_drop", out_valid, 0);
      chk("t1_count", digit_count, 0);

      // 7 with back-pressure and an ignored digit during HOLD
      dig(7);
      step(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, i == 2, 3, 0);
         chk("t2_hold", out_value, 7);
      end
      idle(1);
      chk("t2_drop", out_valid, 0);

      // 9, 9, 5: third rejected, publishes 99
      dig(9); dig(9); dig(5);
      chk("t3_err", err, 1);
      step(1, 0, 1, 0, 0, 0);
      chk("t3_value", out_value, 99);
      idle(1);
      step(1, 1, 0, 0, 0, 0);

      // invalid digit 12 then lone commit
      dig(12);
      chk("t4_err", err, 1);
      step(1, 0, 1, 0, 0, 1);
      chk("t4_novalid", out_valid, 0);

      // clear beats commit; reset mid-entry
      dig(5);
      step(1, 1, 1, 0, 0, 1);
      chk("t5_clr", out_valid, 0);
      dig(5);
      step(0, 0, 1, 0, 0, 1);
      chk("t5_rst", digit_count, 0);

      // commit together with a digit drops the digit without err
      dig(6);
      step(1, 0, 1, 1, 1, 0);
      chk("t6_value", out_value, 6);
      chk("t6_noerr", err, 0);
      idle(1);

      // echo of 3, 8
      dig(3); dig(8);
      step(1, 1, 0, 0, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         int r;
         int d;
         bit rn, clr, cmt, dv;
         r   = int'($urandom_range(0, 99));
         d   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                           : int'($urandom_range(0, 9));
         rn  = (r != 0);
         clr = (r >= 1 && r < 4);
         cmt = (r >= 4 && r < 20);
         dv  = (r >= 20 && r < 70);
         if (r >= 70 && r < 76 && (m_hold || m_cnt > 0)) begin
            cmt = 1; dv = 1;
         end
         step(rn, clr, cmt, dv, d, $urandom_range(0, 2) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
